ss_src_fifo: RTL and testbench
==============================

# ss_src_fifo

Source-side staging FIFO for the stream-processing DMA. It receives 32-bit words fetched by the DMA read engine and packs them little-endian into 64-bit entries. It presents those entries to a processing engine through the active-low pull interface `m_src` / `m_src_getn` / `m_src_empty` / `m_last`. It is the producer end of that interface; the engine is the consumer.

## Interface
Parameters:
- `DEPTH_LOG2`, 4 — log2 of the entry count; DEPTH = 2**DEPTH_LOG2 entries of 65 bits (last + 64 data).

Ports. One clock; reset is synchronous and active-high.
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  synchronous active-high reset
- `ss_dat_i`  in  32  word from the DMA read engine
- `ss_we_i`  in  1  write strobe, active-high
- `ss_last_i`  in  1  qualifies `ss_we_i`: this word is the final word of the descriptor
- `ss_full_o`  out  1  no entry free; writes are refused
- `ss_ovf_o`  out  1  sticky: a write was attempted while `ss_full_o` was high
- `ss_flush_i`  in  1  abort: discard all contents
- `m_src_getn`  in  1  active-low pop strobe from the engine
- `m_src`  out  64  head entry data
- `m_last`  out  1  head entry is the last of its descriptor
- `m_src_empty`  out  1  no entry available
- `m_src_level`  out  DEPTH_LOG2+1  number of entries stored

## Operation
- Packer state machine has two states, `HALF0` and `HALF1`; reset and flush enter `HALF0`.
  - `HALF0` + accepted write, `ss_last_i`=0: latch the word into the low register, go to `HALF1`.
  - `HALF0` + accepted write, `ss_last_i`=1: push `{last=1, 32'h0, dat}`, stay in `HALF0`.
  - `HALF1` + accepted write: push `{last=ss_last_i, dat, low}`, go to `HALF0`.
- A write is accepted when `ss_we_i`=1 and `ss_full_o`=0.
- A write with `ss_full_o`=1 is dropped, sets `ss_ovf_o`, and leaves the packer unchanged. This applies to low-half writes as well.
- A pop happens when `m_src_getn`=0 and `m_src_empty`=0. `m_src_getn`=0 while empty is ignored.
- Push and pop in the same cycle are both performed and the level is unchanged.
- Pointers are DEPTH_LOG2 bits and wrap naturally. The count is DEPTH_LOG2+1 bits.
- `ss_full_o` is asserted when count = DEPTH. `m_src_empty` is asserted when count = 0.
- `m_src` and `m_last` are forced to 0 while `m_src_empty`=1.
- `ss_flush_i` clears the pointers, count, packer state and `ss_ovf_o`. It has priority over a same-cycle write and pop; both are discarded.
- Only reset or flush clears `ss_ovf_o`.

## Timing
- Reset values: `ss_full_o`=0, `ss_ovf_o`=0, `m_src_empty`=1, `m_src`=0, `m_last`=0, `m_src_level`=0. Storage array is not reset.
- Flags and level are registered and update on the edge that performs the push, pop or flush. They are visible the cycle after the event.
- Push-to-visible latency: entry pushed at edge N; `m_src_empty`=0 and `m_src`/`m_last` valid after edge N, i.e. usable in cycle N+1.
- First-word fall-through: the head entry is presented without a pop. After a pop at edge N, the next entry (or empty) is presented in cycle N+1.
- Because `ss_full_o` is registered, a write in the same cycle as a pop from a full FIFO is dropped.

## Structure
- Shared package `ss_pkg`: `SS_DW=32`, `SS_MW=64`, and the packer state enum (`HALF0`, `HALF1`).
- One sub-module, `ss_fifo_mem`: a DEPTH x 65 register array with a single write port and an asynchronous read port. Pointer, count, flag and packer logic stay in `ss_src_fifo`.

## Test plan
- **Reset:** hold `wb_rst_i` 2 cycles → `m_src_empty`=1, `ss_full_o`=0, `m_src_level`=0, `m_src`=0, `m_last`=0, `ss_ovf_o`=0.
- **Pack:** write 32'h11111111 then 32'h22222222 → next cycle `m_src`=64'h22222222_11111111, `m_last`=0, level=1. Pull `m_src_getn` low 1 cycle → `m_src_empty`=1, `m_src`=0.
- **Odd last:** write 0xA, 0xB, 0xC with `ss_last_i` on 0xC → 2 entries: 64'h0000000B_0000000A with last=0, then 64'h00000000_0000000C with last=1.
- **Overflow (DEPTH=16):** write 32 words back-to-back → `ss_full_o`=1 after the 32nd. 33rd write is dropped and `ss_ovf_o`=1. One pop → `ss_full_o`=0 the next cycle. Then drain 16 entries and verify data order.
- **Simultaneous push/pop:** at level 1, complete a pack in the same cycle as a pop → level stays 1, and the new entry appears at head in order.
- **Flush:** with 3 entries stored and the packer in `HALF1`, assert `ss_flush_i` with `ss_we_i`=1 and `m_src_getn`=0 → next cycle level=0, `m_src_empty`=1, `ss_ovf_o`=0. A following 2-word write produces an entry whose low half is the new first word.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared widths and packer state for the source-side staging FIFO.
package ss_pkg;
  localparam int unsigned SS_DW = 32;
  localparam int unsigned SS_MW = 64;

  typedef enum logic {
    HALF0 = 1'b0,
    HALF1 = 1'b1
  } ss_pack_state_e;
endpackage

// File: rtl/ss_fifo_mem.sv
// Entry storage: register array, one synchronous write port, asynchronous read port.
module ss_fifo_mem #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 65
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);
  logic [WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ss_src_fifo.sv
// Packs 32-bit DMA words little-endian into 64-bit entries and presents them
// first-word-fall-through on an active-low pull interface.
module ss_src_fifo
  import ss_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [SS_DW-1:0]      ss_dat_i,
  input  logic                  ss_we_i,
  input  logic                  ss_last_i,
  output logic                  ss_full_o,
  output logic                  ss_ovf_o,
  input  logic                  ss_flush_i,
  input  logic                  m_src_getn,
  output logic [SS_MW-1:0]      m_src,
  output logic                  m_last,
  output logic                  m_src_empty,
  output logic [DEPTH_LOG2:0]   m_src_level
);
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  localparam cnt_t DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  ss_pack_state_e   state_q, state_d;
  logic [SS_DW-1:0] low_q, low_d;
  ptr_t             wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t             count_q, count_d;
  logic             full_q, empty_q, ovf_q, ovf_d;
  logic             push, pop, wr_acc;
  logic [SS_MW:0]   push_entry, head_entry;

  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    push       = 1'b0;
    push_entry = '0;
    wr_acc     = ss_we_i && !full_q;
    pop        = !m_src_getn && !empty_q;

    if (ss_we_i && full_q) begin
      ovf_d = 1'b1;
    end

    if (wr_acc) begin
      unique case (state_q)
        HALF0: begin
          if (ss_last_i) begin
            push       = 1'b1;
            push_entry = {1'b1, {SS_DW{1'b0}}, ss_dat_i};
          end else begin
            low_d   = ss_dat_i;
            state_d = HALF1;
          end
        end
        HALF1: begin
          push       = 1'b1;
          push_entry = {ss_last_i, ss_dat_i, low_q};
          state_d    = HALF0;
        end
        default: state_d = HALF0;
      endcase
    end

    if (push) wptr_d = wptr_q + ptr_t'(1);
    if (pop)  rptr_d = rptr_q + ptr_t'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over any same-cycle push or pop, including the memory write.
    if (ss_flush_i) begin
      state_d = HALF0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= HALF0;
      low_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH);
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
    end
  end

  ss_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (SS_MW + 1)
  ) u_mem (
    .clk_i   (wb_clk_i),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (push_entry),
    .raddr_i (rptr_q),
    .rdata_o (head_entry)
  );

  assign m_src       = empty_q ? '0 : head_entry[SS_MW-1:0];
  assign m_last      = !empty_q && head_entry[SS_MW];
  assign m_src_empty = empty_q;
  assign ss_full_o   = full_q;
  assign ss_ovf_o    = ovf_q;
  assign m_src_level = count_q;
endmodule

// File: tb/tb_ss_src_fifo.sv
// Directed and random stimulus for ss_src_fifo checked against a queue-based reference.
module tb_ss_src_fifo;
  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dat = '0;
  logic        we = 1'b0, last = 1'b0, flush = 1'b0, getn = 1'b1;
  logic        full, ovf, m_empty, m_last_o;
  logic [63:0] m_src_o;
  logic [DL2:0] level;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [64:0] q[$];
  bit          pend;
  logic [31:0] pend_low;
  bit          m_ovf;

  always #5 clk = ~clk;

  ss_src_fifo #(.DEPTH_LOG2(DL2)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .ss_dat_i    (dat),
    .ss_we_i     (we),
    .ss_last_i   (last),
    .ss_full_o   (full),
    .ss_ovf_o    (ovf),
    .ss_flush_i  (flush),
    .m_src_getn  (getn),
    .m_src       (m_src_o),
    .m_last      (m_last_o),
    .m_src_empty (m_empty),
    .m_src_level (level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [64:0] head;
    head = (q.size() == 0) ? 65'd0 : q[0];
    chk("empty", 64'(m_empty), 64'(q.size() == 0));
    chk("full",  64'(full),    64'(q.size() == DEPTH));
    chk("level", 64'(level),   64'(q.size()));
    chk("ovf",   64'(ovf),     64'(m_ovf));
    chk("data",  m_src_o,      head[63:0]);
    chk("last",  64'(m_last_o), 64'(head[64]));
  endtask

  // Reference: applies one clock of the FIFO's rules to the queue model.
  task automatic model_edge(input bit w, input bit l, input logic [31:0] d,
                            input bit gn, input bit fl);
    bit was_full, do_pop;
    was_full = (q.size() == DEPTH);
    do_pop   = !gn && (q.size() != 0);
    if (fl) begin
      q.delete();
      pend  = 0;
      m_ovf = 0;
      return;
    end
    if (do_pop) void'(q.pop_front());
    if (w) begin
      if (was_full) m_ovf = 1;
      else if (pend) begin
        q.push_back({l, d, pend_low});
        pend = 0;
      end else if (l) q.push_back({1'b1, 32'd0, d});
      else begin
        pend     = 1;
        pend_low = d;
      end
    end
  endtask

  task automatic step(input bit w, input bit l, input logic [31:0] d,
                      input bit gn, input bit fl);
    we = w; last = l; dat = d; getn = gn; flush = fl;
    @(posedge clk);
    model_edge(w, l, d, gn, fl);
    #1;
    we = 0; last = 0; getn = 1; flush = 0;
    check_all();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete(); pend = 0; m_ovf = 0;
    check_all();

    // Pack two words, then pop
    step(1, 0, 32'h11111111, 1, 0);
    step(1, 0, 32'h22222222, 1, 0);
    chk("pack_data", m_src_o, 64'h22222222_11111111);
    chk("pack_level", 64'(level), 64'd1);
    step(0, 0, 32'h0, 0, 0);
    chk("pop_zero", m_src_o, 64'd0);

    // Odd word count with last
    step(1, 0, 32'hA, 1, 0);
    step(1, 0, 32'hB, 1, 0);
    step(1, 1, 32'hC, 1, 0);
    chk("odd_e0", m_src_o, 64'h0000000B_0000000A);
    step(0, 0, 32'h0, 0, 0);
    chk("odd_e1", m_src_o, 64'h00000000_0000000C);
    chk("odd_last", 64'(m_last_o), 64'd1);
    step(0, 0, 32'h0, 0, 0);

    // Fill to full, overflow, pop, drain
    for (int i = 0; i < 32; i++) step(1, 0, 32'h1000 + 32'(i), 1, 0);
    chk("ovf_full", 64'(full), 64'd1);
    step(1, 0, 32'hDEAD, 1, 0);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    step(0, 0, 32'h0, 0, 0);
    chk("ovf_unfull", 64'(full), 64'd0);
    for (int i = 0; i < 16 && q.size() != 0; i++) step(0, 0, 32'h0, 0, 0);

    // Simultaneous push and pop at level 1
    step(1, 0, 32'h31, 1, 0);
    step(1, 0, 32'h32, 1, 0);
    step(1, 0, 32'h41, 1, 0);
    step(1, 0, 32'h42, 0, 0);
    chk("sim_level", 64'(level), 64'd1);
    chk("sim_head", m_src_o, 64'h00000042_00000041);
    step(0, 0, 32'h0, 0, 0);

    // Flush with 3 entries and a pending low half
    for (int i = 0; i < 7; i++) step(1, 0, 32'h500 + 32'(i), 1, 0);
    step(1, 0, 32'hBAD, 0, 1);
    chk("flush_level", 64'(level), 64'd0);
    step(1, 0, 32'h77, 1, 0);
    step(1, 0, 32'h88, 1, 0);
    chk("flush_low", m_src_o, 64'h00000088_00000077);
    step(0, 0, 32'h0, 0, 0);

    // Random traffic: fill-biased then drain-biased
    for (int i = 0; i < 400; i++) begin
      bit w, l, gn, fl;
      w  = ($urandom % 4) != 0;
      l  = ($urandom % 5) == 0;
      gn = (i < 200) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      fl = ($urandom % 64) == 0;
      step(w, l, $urandom, gn, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
